mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Load/store initiator sitting in the MEM stage between the pipeline and the byte-selectable data RAM.
- Accepts one load/store request at a time via a valid/ready handshake.
- Drives the RAM's rw/sel/addr/data_in for exactly one cycle.
- Captures the RAM's registered read data, which arrives right-justified and zero-extended, then sign- or zero-extends it per opcode.
- Returns a one-cycle response pulse. Misaligned or out-of-range requests are rejected without touching the RAM.

Parameters:
- RAM_AW, 10, RAM word-address width; byte address bits [RAM_AW+1:2] form ram_addr.
- CHECK_RANGE, 1, when 1 any nonzero address bit above RAM_AW+1 flags resp_err; when 0 those bits are ignored (aliasing).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_op  in  3  opcode, from the shared package
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range, or undefined op; valid with resp_valid
- ram_rw  out  1  1 = write; to RAM
- ram_sel  out  4  byte-lane enables; to RAM
- ram_addr  out  RAM_AW  word address; to RAM
- ram_data_in  out  32  lane-positioned write data; to RAM
- ram_data_out  in  32  RAM registered read data, right-justified, zero-extended

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, ram_rw=0, ram_sel=0, ram_addr=0, ram_data_in=0.
- All outputs except req_ready are registered.
- Opcodes: LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7.
- Lane select by addr[1:0]:
  - byte ops: sel=0001<<addr[1:0]
  - half ops: 0011 for addr[1:0]=00, 1100 for addr[1:0]=10
  - word ops: 1111
- Store data placement: byte data replicated/shifted into lane addr[1:0]*8; half data into [15:0] or [31:16]; word data unchanged.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=00, is an error.
- FSM states and transitions:
  - IDLE: accept on req_valid&&req_ready. Legal request → ACCESS, with ram_* registered from the request (ram_rw=1 only for stores). Illegal request → RESP with resp_err=1, rdata=0; ram_* stay idle (rw=0, sel=0).
  - ACCESS: ram_* held for exactly one cycle. Store → RESP. Load → CAPTURE. On exit, ram_rw and ram_sel return to 0.
  - CAPTURE: ram_data_out is valid this cycle. Extend it: LB sign-extends bit 7, LH sign-extends bit 15, LBU/LHU/LW pass through. Register the result into resp_rdata; → RESP.
  - RESP: resp_valid=1 for one cycle, no backpressure; → IDLE. resp_rdata/resp_err hold until the next response.
- Latency from the accept edge: store completes with RAM write at end of cycle 1 and resp_valid in cycle 2; load has resp_valid in cycle 3; error has resp_valid in cycle 1.
- Throughput: one request per 3 (store), 4 (load) or 2 (error) cycles.
- req_ready is low in ACCESS/CAPTURE/RESP; req_valid there is ignored.
- Reset mid-operation: at the rst edge everything returns to reset values. An in-flight store whose ACCESS cycle coincides with the rst edge is not guaranteed written (the RAM clears anyway); no resp_valid is produced.

Decomposition:
- Shared package mau_pkg: opcode localparams, FSM state encodings, and helper widths (RAM_AW default).
- Sub-module mau_align (combinational): from op/addr/wdata it produces sel, the placed store data and the error flag; from op/ram_data_out it produces the extended load data.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF → ACCESS cycle: ram_rw=1, ram_addr=4, sel=1111, data_in=0xDEADBEEF; resp_valid 2 cycles after accept, err=0, rdata=0.
- SB addr 0x13 data 0x000000A5 → sel=1000, data_in[31:24]=0xA5; then LW 0x10 → rdata=0xA5ADBEEF, resp_valid 3 cycles after accept.
- LB 0x13 → 0xFFFFFFA5; LBU 0x13 → 0x000000A5; LH 0x12 → sel=1100, rdata=0xFFFFA5AD; LHU 0x12 → 0x0000A5AD.
- LW 0x11, LH 0x13, SH 0x15 → resp_err=1, rdata=0, ram_rw and ram_sel never nonzero, resp_valid 1 cycle after accept. With CHECK_RANGE=1, LW 0x1000 → err=1.
- Back-to-back req_valid held high → req_ready low outside IDLE, every request accepted exactly once, and resp_valid pulses match the request count.
- rst asserted during ACCESS of SW → next cycle all outputs at reset values, req_ready=1, no resp_valid.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared definitions for the MEM-stage load/store initiator: opcodes, FSM states
// and the default RAM word-address width.
package mau_pkg;

    localparam int RAM_AW_DEF = 10;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } mau_state_e;

    function automatic logic op_is_store(input logic [2:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mau_align.sv
// Combinational lane logic: byte enables, store-data placement, legality check,
// and sign/zero extension of right-justified RAM read data.
module mau_align
    import mau_pkg::*;
#(
    parameter int RAM_AW      = RAM_AW_DEF,
    parameter int CHECK_RANGE = 1
) (
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  ld_op,
    input  logic [31:0] ram_rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata_placed,
    output logic        err,
    output logic [31:0] ld_data
);

    logic misalign;
    logic range_err;

    // Address bits above the RAM window either fault or alias onto the RAM.
    generate
        if (CHECK_RANGE != 0 && RAM_AW < 30) begin : g_range
            assign range_err = |addr[31:RAM_AW+2];
        end else begin : g_no_range
            assign range_err = 1'b0;
        end
    endgenerate

    always_comb begin
        sel          = 4'b0000;
        wdata_placed = 32'h0;
        misalign     = 1'b0;
        case (op)
            OP_LB, OP_LBU, OP_SB: begin
                sel          = 4'b0001 << addr[1:0];
                wdata_placed = {4{wdata[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                sel          = addr[1] ? 4'b1100 : 4'b0011;
                wdata_placed = {2{wdata[15:0]}};
                misalign     = addr[0];
            end
            default: begin
                sel          = 4'b1111;
                wdata_placed = wdata;
                misalign     = |addr[1:0];
            end
        endcase
    end

    assign err = misalign | range_err;

    // RAM already right-justifies and zero-extends, so only signed loads need work.
    always_comb begin
        ld_data = ram_rdata;
        case (ld_op)
            OP_LB:   ld_data = {{24{ram_rdata[7]}}, ram_rdata[7:0]};
            OP_LH:   ld_data = {{16{ram_rdata[15]}}, ram_rdata[15:0]};
            default: ld_data = ram_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: one request at a time, one RAM access cycle,
// registered response pulse; illegal requests never touch the RAM.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int RAM_AW      = RAM_AW_DEF,
    parameter int CHECK_RANGE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_rw,
    output logic [3:0]        ram_sel,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_data_in,
    input  logic [31:0]       ram_data_out
);

    mau_state_e        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              ram_rw_q, ram_rw_d;
    logic [3:0]        ram_sel_q, ram_sel_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_data_in_q, ram_data_in_d;

    logic [3:0]  al_sel;
    logic [31:0] al_wdata;
    logic        al_err;
    logic [31:0] al_ld_data;

    mau_align #(
        .RAM_AW      (RAM_AW),
        .CHECK_RANGE (CHECK_RANGE)
    ) u_align (
        .op           (req_op),
        .addr         (req_addr),
        .wdata        (req_wdata),
        .ld_op        (op_q),
        .ram_rdata    (ram_data_out),
        .sel          (al_sel),
        .wdata_placed (al_wdata),
        .err          (al_err),
        .ld_data      (al_ld_data)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        resp_valid_d  = resp_valid_q;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        ram_rw_d      = ram_rw_q;
        ram_sel_d     = ram_sel_q;
        ram_addr_d    = ram_addr_q;
        ram_data_in_d = ram_data_in_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d = req_op;
                    if (al_err) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                        state_d      = ST_RESP;
                    end else begin
                        ram_rw_d      = op_is_store(req_op);
                        ram_sel_d     = al_sel;
                        ram_addr_d    = req_addr[RAM_AW+1:2];
                        ram_data_in_d = al_wdata;
                        state_d       = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                ram_rw_d  = 1'b0;
                ram_sel_d = 4'b0000;
                if (op_is_store(op_q)) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'h0;
                    state_d      = ST_RESP;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = al_ld_data;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                resp_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_LB;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'h0;
            resp_err_q    <= 1'b0;
            ram_rw_q      <= 1'b0;
            ram_sel_q     <= 4'b0000;
            ram_addr_q    <= '0;
            ram_data_in_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            ram_rw_q      <= ram_rw_d;
            ram_sel_q     <= ram_sel_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_in_q <= ram_data_in_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign ram_rw      = ram_rw_q;
    assign ram_sel     = ram_sel_q;
    assign ram_addr    = ram_addr_q;
    assign ram_data_in = ram_data_in_q;

endmodule
